sw_pkt_rr_arbiter: RTL and testbench

// Packet-granular round-robin arbiter that merges NUM_PORTS 32-bit Sop/Eop/Valid/Keep streams

---
 rtl/sw_pkt_rr_arbiter.sv | 102 ++++++++++
 tb/tb_sw_pkt_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_pkt_rr_arbiter.sv
// sw_pkt_rr_arbiter: packet-granular round-robin merge of NUM_PORTS Sop/Eop streams onto one registered egress.
module sw_pkt_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                                   SysClk,
  input  logic                                   Rst_n,
  input  logic                                   CntClr,
  input  logic [NUM_PORTS-1:0]                   InValid,
  input  logic [NUM_PORTS-1:0]                   InSop,
  input  logic [NUM_PORTS-1:0]                   InEop,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]       InData,
  input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]     InKeep,
  output logic [NUM_PORTS-1:0]                   InReady,
  input  logic                                   OutReady,
  output logic                                   OutValid,
  output logic                                   OutSop,
  output logic                                   OutEop,
  output logic [DATA_W-1:0]                      OutData,
  output logic [DATA_W/8-1:0]                    OutKeep,
  output logic [2:0]                             GrantId,
  output logic                                   ErrTimeout,
  output logic [15:0]                            OrphanCnt,
  output logic [15:0]                            OutPktCnt
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_d;
  logic [IW-1:0] grant, rr_ptr, pick, grant_nxt;
  logic [NUM_PORTS-1:0] cand, orph_vec;
  logic [WW-1:0] wd_cnt;
  logic pick_vld, stage_free, acc, acc_eop, wd_hit, orphan;
  assign stage_free = ~OutValid | OutReady;
  assign cand       = InValid & InSop;
  assign orph_vec   = InValid & ~InSop;
  assign orphan     = (state == IDLE) && |orph_vec;
  assign acc        = (state == LOCK) && InValid[grant] && stage_free;
  assign acc_eop    = acc && InEop[grant];
  assign wd_hit     = (state == LOCK) && !acc && (wd_cnt == WW'(TIMEOUT - 1));
  assign grant_nxt  = (grant == IW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
  assign GrantId    = 3'(grant);
  // Scan downward so the lowest offset from rr_ptr wins, giving wrap-around priority.
  always_comb begin
    logic [IW:0] s;
    pick     = '0;
    pick_vld = 1'b0;
    s        = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      s = {1'b0, rr_ptr} + (IW+1)'(k);
      s = (s >= (IW+1)'(NUM_PORTS)) ? s - (IW+1)'(NUM_PORTS) : s;
      if (cand[s[IW-1:0]]) begin
        pick     = s[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end
  always_ff @(posedge SysClk or negedge Rst_n)
    if (!Rst_n) state <= IDLE;
    else        state <= state_d;
  always_comb
    state_d = (state == IDLE) ? (pick_vld ? LOCK : IDLE) : ((acc_eop || wd_hit) ? IDLE : LOCK);
  always_comb
    InReady = (state == IDLE) ? orph_vec : (stage_free ? NUM_PORTS'(1) << grant : '0);
  always_ff @(posedge SysClk or negedge Rst_n)
    if (!Rst_n) begin
      grant      <= '0;
      rr_ptr     <= '0;
      wd_cnt     <= '0;
      ErrTimeout <= 1'b0;
    end else begin
      ErrTimeout <= wd_hit;
      if (state == IDLE && pick_vld) grant <= pick;
      if (acc_eop || wd_hit) rr_ptr <= grant_nxt;
      wd_cnt <= (state == IDLE || acc) ? '0 : wd_cnt + 1'b1;
    end
  always_ff @(posedge SysClk or negedge Rst_n)
    if (!Rst_n) begin
      OutValid <= 1'b0;
      OutSop   <= 1'b0;
      OutEop   <= 1'b0;
      OutData  <= '0;
      OutKeep  <= '0;
    end else if (acc) begin
      OutValid <= 1'b1;
      OutSop   <= InSop[grant];
      OutEop   <= InEop[grant];
      OutData  <= InData[grant];
      OutKeep  <= InKeep[grant];
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  always_ff @(posedge SysClk or negedge Rst_n)
    if (!Rst_n) begin
      OrphanCnt <= '0;
      OutPktCnt <= '0;
    end else begin
      OrphanCnt <= CntClr ? '0 : OrphanCnt + 16'(orphan);
      OutPktCnt <= CntClr ? '0 : OutPktCnt + 16'(OutValid & OutReady & OutEop);
    end
endmodule

// File: tb/tb_sw_pkt_rr_arbiter.sv
// tb_sw_pkt_rr_arbiter: scoreboard bench; expected egress beats are queued in predicted grant order.
module tb_sw_pkt_rr_arbiter;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int TO = 16;
  logic SysClk = 1'b0, Rst_n = 1'b0, CntClr = 1'b0, OutReady = 1'b1;
  logic [NP-1:0] InValid, InSop, InEop, InReady;
  logic [NP-1:0][DW-1:0] InData;
  logic [NP-1:0][KW-1:0] InKeep;
  logic OutValid, OutSop, OutEop, ErrTimeout;
  logic [DW-1:0] OutData;
  logic [KW-1:0] OutKeep;
  logic [2:0] GrantId;
  logic [15:0] OrphanCnt, OutPktCnt;
  logic v[NP], s[NP], e[NP];
  logic [DW-1:0] d[NP];
  logic [KW-1:0] k[NP];
  logic [37:0] q[$];
  int checks = 0, failures = 0, cyc = 0, exp_pkts = 0;
  int last_acc[NP];
  int phase = 0, last_out = -1, errs = 0, err_cyc = 0, lat_start = 0, lat_got = -1;
  bit sb_on = 1'b1, tog_en = 1'b0, lat_arm = 1'b0;

  sw_pkt_rr_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .SysClk(SysClk), .Rst_n(Rst_n), .CntClr(CntClr),
    .InValid(InValid), .InSop(InSop), .InEop(InEop), .InData(InData), .InKeep(InKeep),
    .InReady(InReady), .OutReady(OutReady), .OutValid(OutValid), .OutSop(OutSop),
    .OutEop(OutEop), .OutData(OutData), .OutKeep(OutKeep), .GrantId(GrantId),
    .ErrTimeout(ErrTimeout), .OrphanCnt(OrphanCnt), .OutPktCnt(OutPktCnt)
  );

  always #5 SysClk = ~SysClk;
  always @(posedge SysClk) cyc <= cyc + 1;

  always_comb
    for (int i = 0; i < NP; i++) begin
      InValid[i] = v[i];
      InSop[i]   = s[i];
      InEop[i]   = e[i];
      InData[i]  = d[i];
      InKeep[i]  = k[i];
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] beat(input int p, input int n, input int tag, input int j,
                                       input bit sop_en, input bit eop_en, input logic [3:0] kl);
    bit sop, eop;
    sop = sop_en && j == 0;
    eop = eop_en && j == n - 1;
    return {sop, eop, eop ? kl : 4'hf, 8'(p), 8'(tag), 16'(j)};
  endfunction

  task automatic push_pkt(input int p, input int n, input int tag, input bit sop_en,
                          input bit eop_en, input logic [3:0] kl);
    for (int j = 0; j < n; j++) q.push_back(beat(p, n, tag, j, sop_en, eop_en, kl));
    if (eop_en) exp_pkts++;
  endtask

  task automatic send_pkt(input int p, input int n, input int tag, input bit sop_en,
                          input bit eop_en, input logic [3:0] kl);
    for (int j = 0; j < n; j++) begin
      logic [37:0] b;
      int t;
      b = beat(p, n, tag, j, sop_en, eop_en, kl);
      v[p] = 1'b1; s[p] = b[37]; e[p] = b[36]; k[p] = b[35:32]; d[p] = b[31:0];
      t = 0;
      do begin
        @(negedge SysClk);
        t++;
      end while (!InReady[p] && t < 2000);
      check($sformatf("accept_p%0d", p), 64'(t < 2000), 1);
      last_acc[p] = cyc + 1;
      @(posedge SysClk);
      #1;
    end
    v[p] = 1'b0; s[p] = 1'b0; e[p] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((q.size() != 0 || OutValid) && t < 1000) begin
      @(negedge SysClk);
      t++;
    end
    check(tag, 64'(q.size() == 0 && t < 1000), 1);
    @(posedge SysClk);
    #1;
  endtask

  initial forever begin
    @(posedge SysClk);
    #1;
    OutReady = tog_en ? ~OutReady : 1'b1;
  end

  // Egress monitor: scoreboard compare, stall stability, spacing and latency capture.
  initial begin
    logic [37:0] cur, prev_w;
    bit stall_prev;
    stall_prev = 1'b0;
    prev_w = '0;
    forever begin
      @(negedge SysClk);
      if (sb_on) begin
        cur = {OutSop, OutEop, OutKeep, OutData};
        if (stall_prev) check("stable", 64'(cur), 64'(prev_w));
        stall_prev = OutValid & ~OutReady;
        prev_w = cur;
        if (lat_arm && OutValid) begin
          lat_got = cyc - lat_start;
          lat_arm = 1'b0;
        end
        if (OutValid && OutReady) begin
          if (q.size() == 0) check("unexpected_beat", 64'(cur), 0);
          else check("beat", 64'(cur), 64'(q.pop_front()));
          if (phase == 1) begin
            if (last_out >= 0) check("spacing", 64'(cyc - last_out), 2);
            last_out = cyc;
          end
        end
        if (ErrTimeout) begin
          errs++;
          err_cyc = cyc;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NP; i++) begin
      v[i] = 1'b0; s[i] = 1'b0; e[i] = 1'b0; d[i] = '0; k[i] = '0; last_acc[i] = 0;
    end
    repeat (3) @(posedge SysClk);
    #1 Rst_n = 1'b1;
    @(negedge SysClk);
    check("rst_outvalid", 64'(OutValid), 0);
    check("rst_inready", 64'(InReady), 0);
    check("rst_grant", 64'(GrantId), 0);
    check("rst_err", 64'(ErrTimeout), 0);
    check("rst_orphan", 64'(OrphanCnt), 0);
    check("rst_pktcnt", 64'(OutPktCnt), 0);
    @(posedge SysClk);
    #1;
    // Non-Sop beats while idle are swallowed and counted once per cycle.
    send_pkt(0, 3, 1, 1'b0, 1'b0, 4'hf);
    repeat (2) @(negedge SysClk);
    check("orphan_cnt", 64'(OrphanCnt), 3);
    check("orphan_no_out", 64'(OutValid), 0);
    @(posedge SysClk);
    #1;
    v[0] = 1'b1; s[0] = 1'b0; d[0] = 32'hdead; CntClr = 1'b1;
    @(negedge SysClk);
    check("orphan_ready", 64'(InReady[0]), 1);
    @(posedge SysClk);
    #1;
    v[0] = 1'b0; CntClr = 1'b0;
    @(negedge SysClk);
    check("cntclr_prio", 64'(OrphanCnt), 0);
    @(posedge SysClk);
    #1;
    // Four simultaneous packets from pointer 0: order 0,1,2,3.
    for (int p = 0; p < NP; p++) push_pkt(p, 4, 2, 1'b1, 1'b1, 4'hf);
    lat_start = cyc;
    lat_arm = 1'b1;
    fork
      send_pkt(0, 4, 2, 1'b1, 1'b1, 4'hf);
      send_pkt(1, 4, 2, 1'b1, 1'b1, 4'hf);
      send_pkt(2, 4, 2, 1'b1, 1'b1, 4'hf);
      send_pkt(3, 4, 2, 1'b1, 1'b1, 4'hf);
    join
    drain("drain_rr4");
    check("latency", 64'(lat_got), 2);
    check("pktcnt_rr4", 64'(OutPktCnt), 64'(exp_pkts));
    // Long packet under egress backpressure toggling each cycle.
    tog_en = 1'b1;
    push_pkt(2, 64, 3, 1'b1, 1'b1, 4'h1);
    send_pkt(2, 64, 3, 1'b1, 1'b1, 4'h1);
    drain("drain_long");
    tog_en = 1'b0;
    @(posedge SysClk);
    #1;
    // Port 1 back-to-back; port 3 must get in between its packets.
    push_pkt(1, 4, 4, 1'b1, 1'b1, 4'h3);
    push_pkt(3, 2, 5, 1'b1, 1'b1, 4'h7);
    push_pkt(1, 4, 6, 1'b1, 1'b1, 4'h3);
    fork
      begin
        send_pkt(1, 4, 4, 1'b1, 1'b1, 4'h3);
        send_pkt(1, 4, 6, 1'b1, 1'b1, 4'h3);
      end
      begin
        repeat (2) @(posedge SysClk);
        #1;
        send_pkt(3, 2, 5, 1'b1, 1'b1, 4'h7);
      end
    join
    drain("drain_fair");
    // Port 1 stalls after Sop; watchdog revokes and port 2 follows.
    push_pkt(1, 1, 7, 1'b1, 1'b0, 4'hf);
    push_pkt(2, 3, 8, 1'b1, 1'b1, 4'h7);
    fork
      send_pkt(1, 1, 7, 1'b1, 1'b0, 4'hf);
      begin
        repeat (3) @(posedge SysClk);
        #1;
        send_pkt(2, 3, 8, 1'b1, 1'b1, 4'h7);
      end
    join
    drain("drain_timeout");
    check("timeout_pulses", 64'(errs), 1);
    check("timeout_delay", 64'(err_cyc - last_acc[1]), 16);
    // Single-beat packets on all ports; pointer sits at 3 after port 2's packet.
    phase = 1;
    push_pkt(3, 1, 9, 1'b1, 1'b1, 4'b0011);
    push_pkt(0, 1, 9, 1'b1, 1'b1, 4'b0011);
    push_pkt(1, 1, 9, 1'b1, 1'b1, 4'b0011);
    push_pkt(2, 1, 9, 1'b1, 1'b1, 4'b0011);
    fork
      send_pkt(0, 1, 9, 1'b1, 1'b1, 4'b0011);
      send_pkt(1, 1, 9, 1'b1, 1'b1, 4'b0011);
      send_pkt(2, 1, 9, 1'b1, 1'b1, 4'b0011);
      send_pkt(3, 1, 9, 1'b1, 1'b1, 4'b0011);
    join
    drain("drain_single");
    phase = 0;
    check("spacing_seen", 64'(last_out >= 0), 1);
    check("pktcnt_total", 64'(OutPktCnt), 64'(exp_pkts));
    check("err_total", 64'(errs), 1);
    check("sb_empty", 64'(q.size()), 0);
    // Reset in the middle of a packet on port 2.
    sb_on = 1'b0;
    v[2] = 1'b1; s[2] = 1'b1; e[2] = 1'b0; d[2] = 32'h1234; k[2] = 4'hf;
    repeat (4) @(posedge SysClk);
    #2;
    check("mid_valid", 64'(OutValid), 1);
    check("mid_grant", 64'(GrantId), 2);
    Rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(OutValid), 0);
    check("arst_grant", 64'(GrantId), 0);
    check("arst_ready", 64'(InReady), 0);
    check("arst_pktcnt", 64'(OutPktCnt), 0);
    check("arst_data", 64'(OutData), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
